// File: rtl/tx_frame_ser.sv
// tx_frame_ser: backscatter frame serializer (pilot, preamble, payload, dummy '1') feeding the FM0/Miller modulator.
// Define TX_FRAME_SER_CRC16_EN to append a CRC-16/CCITT trailer between payload and dummy bit.
module tx_frame_ser #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_m_dec,
    input  logic              i_trext,
    input  logic              i_en2blf,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_clear_cu,
    output logic              o_data_ocu,
    output logic              o_enable_mod,
    output logic              o_violate_mod,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PILOT,
        S_PREAMB,
        S_PAYLOAD,
`ifdef TX_FRAME_SER_CRC16_EN
        S_CRC,
`endif
        S_DUMMY,
        S_DONE
    } state_t;

    // Bit k of each pattern is the k-th preamble symbol sent.
    localparam logic [5:0] PRE_FM0 = 6'b100101;
    localparam logic [5:0] PRE_MIL = 6'b111010;

    state_t             state;
    logic [1:0]         m_dec;
    logic               trext;
    logic [3:0]         tick;
    logic [3:0]         pilot_cnt;
    logic [2:0]         pre_idx;
    logic [LEN_W-1:0]   pay_cnt;
    logic [DATA_W-1:0]  shreg;

    logic [3:0]         tick_max;
    logic [3:0]         pilot_last;
    logic [5:0]         pre_bits;
    logic [LEN_W-1:0]   len_c;
    logic               tick_wrap;

    always_comb begin
        case (m_dec)
            2'b01:   tick_max = 4'd3;
            2'b10:   tick_max = 4'd7;
            2'b11:   tick_max = 4'd15;
            default: tick_max = 4'd1;
        endcase
        pilot_last = (m_dec == 2'b00) ? 4'd11 : (trext ? 4'd15 : 4'd3);
        pre_bits   = (m_dec == 2'b00) ? PRE_FM0 : PRE_MIL;
        len_c      = (i_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_len;
    end

    assign tick_wrap = (tick == tick_max);
    assign o_busy    = (state != S_IDLE);

`ifdef TX_FRAME_SER_CRC16_EN
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic [3:0]  crc_cnt;

    // The bit being shifted in is the payload bit currently on the line.
    assign crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ o_data_ocu) ? 16'h1021 : 16'h0000);
`endif

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every branch reads the pre-edge values of the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            m_dec         <= 2'b00;
            trext         <= 1'b0;
            tick          <= 4'd0;
            pilot_cnt     <= 4'd0;
            pre_idx       <= 3'd0;
            pay_cnt       <= '0;
            shreg         <= '0;
            o_data_ocu    <= 1'b0;
            o_enable_mod  <= 1'b0;
            o_violate_mod <= 1'b0;
            o_done        <= 1'b0;
`ifdef TX_FRAME_SER_CRC16_EN
            crc           <= 16'hFFFF;
            crc_cnt       <= 4'd0;
`endif
        end else if (i_clear_cu) begin
            state         <= S_IDLE;
            m_dec         <= 2'b00;
            trext         <= 1'b0;
            tick          <= 4'd0;
            pilot_cnt     <= 4'd0;
            pre_idx       <= 3'd0;
            pay_cnt       <= '0;
            shreg         <= '0;
            o_data_ocu    <= 1'b0;
            o_enable_mod  <= 1'b0;
            o_violate_mod <= 1'b0;
            o_done        <= 1'b0;
`ifdef TX_FRAME_SER_CRC16_EN
            crc           <= 16'hFFFF;
            crc_cnt       <= 4'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        m_dec        <= i_m_dec;
                        trext        <= i_trext;
                        tick         <= 4'd0;
                        pilot_cnt    <= 4'd0;
                        pre_idx      <= 3'd0;
                        pay_cnt      <= len_c;
                        // Left-justify the payload so the first bit is always the MSB.
                        shreg        <= i_data << (DATA_W - int'(len_c));
                        o_enable_mod <= 1'b1;
`ifdef TX_FRAME_SER_CRC16_EN
                        crc          <= 16'hFFFF;
                        crc_cnt      <= 4'd0;
`endif
                        if (i_m_dec == 2'b00 && !i_trext) begin
                            state      <= S_PREAMB;
                            o_data_ocu <= PRE_FM0[0];
                        end else begin
                            state      <= S_PILOT;
                            o_data_ocu <= 1'b0;
                        end
                    end
                end

                S_DONE: begin
                    o_done <= 1'b1;
                    state  <= S_IDLE;
                end

                default: begin
                    if (i_en2blf) begin
                        tick <= tick_wrap ? 4'd0 : tick + 4'd1;
                        if (tick_wrap) begin
                            case (state)
                                S_PILOT: begin
                                    if (pilot_cnt == pilot_last) begin
                                        state      <= S_PREAMB;
                                        o_data_ocu <= pre_bits[0];
                                    end else begin
                                        pilot_cnt  <= pilot_cnt + 4'd1;
                                    end
                                end

                                S_PREAMB: begin
                                    if (pre_idx == 3'd5) begin
                                        o_violate_mod <= 1'b0;
                                        if (pay_cnt != '0) begin
                                            state      <= S_PAYLOAD;
                                            o_data_ocu <= shreg[DATA_W-1];
                                        end else begin
`ifdef TX_FRAME_SER_CRC16_EN
                                            state      <= S_CRC;
                                            crc        <= ~crc;
                                            o_data_ocu <= ~crc[15];
`else
                                            state      <= S_DUMMY;
                                            o_data_ocu <= 1'b1;
`endif
                                        end
                                    end else begin
                                        pre_idx       <= pre_idx + 3'd1;
                                        o_data_ocu    <= pre_bits[pre_idx + 3'd1];
                                        o_violate_mod <= (m_dec == 2'b00) && (pre_idx == 3'd3);
                                    end
                                end

                                S_PAYLOAD: begin
                                    pay_cnt <= pay_cnt - LEN_W'(1);
                                    shreg   <= shreg << 1;
                                    if (pay_cnt == LEN_W'(1)) begin
`ifdef TX_FRAME_SER_CRC16_EN
                                        state      <= S_CRC;
                                        crc        <= ~crc_next;
                                        o_data_ocu <= ~crc_next[15];
`else
                                        state      <= S_DUMMY;
                                        o_data_ocu <= 1'b1;
`endif
                                    end else begin
`ifdef TX_FRAME_SER_CRC16_EN
                                        crc        <= crc_next;
`endif
                                        o_data_ocu <= shreg[DATA_W-2];
                                    end
                                end

`ifdef TX_FRAME_SER_CRC16_EN
                                S_CRC: begin
                                    crc     <= {crc[14:0], 1'b0};
                                    crc_cnt <= crc_cnt + 4'd1;
                                    if (crc_cnt == 4'd15) begin
                                        state      <= S_DUMMY;
                                        o_data_ocu <= 1'b1;
                                    end else begin
                                        o_data_ocu <= crc[14];
                                    end
                                end
`endif

                                S_DUMMY: begin
                                    state        <= S_DONE;
                                    o_enable_mod <= 1'b0;
                                    o_data_ocu   <= 1'b0;
                                    tick         <= 4'd0;
                                end

                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_ser.sv
// tb_tx_frame_ser: table vectors, hand-written abort/reset sequences and random frames
// checked against a symbol-list model of tx_frame_ser.
module tb_tx_frame_ser;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_m_dec;
    logic        i_trext;
    logic        i_en2blf;
    logic        i_start;
    logic [15:0] i_data;
    logic [4:0]  i_len;
    logic        i_clear_cu;
    logic        o_data_ocu;
    logic        o_enable_mod;
    logic        o_violate_mod;
    logic        o_busy;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    bit exp_bits[$];
    bit exp_vio[$];
    bit obs_bits[$];

    typedef struct {
        logic [1:0]  m;
        bit          tx;
        logic [15:0] d;
        logic [4:0]  len;
        int          gap;
        int          nsym;
        logic [63:0] pat;
        int          vio_sym;
        int          spur;
    } vec_t;

    tx_frame_ser #(.DATA_W(16), .LEN_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_m_dec      (i_m_dec),
        .i_trext      (i_trext),
        .i_en2blf     (i_en2blf),
        .i_start      (i_start),
        .i_data       (i_data),
        .i_len        (i_len),
        .i_clear_cu   (i_clear_cu),
        .o_data_ocu   (o_data_ocu),
        .o_enable_mod (o_enable_mod),
        .o_violate_mod(o_violate_mod),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
        logic fb;
        fb = c[15] ^ b;
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    function automatic logic [15:0] model_crc(input logic [15:0] d, input int lc);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = lc - 1; i >= 0; i--) c = crc_step(c, d[i]);
        return ~c;
    endfunction

    // Symbol list straight from the frame rules: pilot zeros, preamble, payload, [CRC], dummy.
    task automatic build_model(input logic [1:0] m, input bit tx, input logic [15:0] d, input logic [4:0] len);
        bit fm0_pre[6] = '{1, 0, 1, 0, 0, 1};
        bit mil_pre[6] = '{0, 1, 0, 1, 1, 1};
        int npilot;
        int lc;
        logic [15:0] crc;
        exp_bits.delete();
        exp_vio.delete();
        npilot = (m == 2'b00) ? (tx ? 12 : 0) : (tx ? 16 : 4);
        for (int i = 0; i < npilot; i++) begin
            exp_bits.push_back(1'b0);
            exp_vio.push_back(1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            exp_bits.push_back((m == 2'b00) ? fm0_pre[i] : mil_pre[i]);
            exp_vio.push_back((m == 2'b00) && (i == 4));
        end
        lc = (int'(len) > 16) ? 16 : int'(len);
        for (int i = lc - 1; i >= 0; i--) begin
            exp_bits.push_back(d[i]);
            exp_vio.push_back(1'b0);
        end
`ifdef TX_FRAME_SER_CRC16_EN
        crc = model_crc(d, lc);
        for (int i = 15; i >= 0; i--) begin
            exp_bits.push_back(crc[i]);
            exp_vio.push_back(1'b0);
        end
`else
        crc = 16'h0;
`endif
        exp_bits.push_back(1'b1);
        exp_vio.push_back(1'b0);
    endtask

    task automatic fill_table(input vec_t v);
        int lc;
        logic [15:0] crc;
        exp_bits.delete();
        exp_vio.delete();
        for (int i = v.nsym - 1; i >= 0; i--) begin
            exp_bits.push_back(v.pat[i]);
            exp_vio.push_back((v.nsym - 1 - i) == v.vio_sym);
        end
`ifdef TX_FRAME_SER_CRC16_EN
        void'(exp_bits.pop_back());
        void'(exp_vio.pop_back());
        lc  = (int'(v.len) > 16) ? 16 : int'(v.len);
        crc = model_crc(v.d, lc);
        for (int i = 15; i >= 0; i--) begin
            exp_bits.push_back(crc[i]);
            exp_vio.push_back(1'b0);
        end
        exp_bits.push_back(1'b1);
        exp_vio.push_back(1'b0);
`else
        lc  = 0;
        crc = 16'h0;
`endif
    endtask

    // Runs one frame against exp_bits/exp_vio; clear_at/spur are strobe indices (-1 = none).
    task automatic run_frame(input logic [1:0] m, input bit tx, input logic [15:0] d, input logic [4:0] len,
                             input int gap, input int clear_at, input int spur);
        int symlen;
        int total;
        int s;
        int cyc;
        bit strobe;
        symlen = (m == 2'b00) ? 2 : (2 << m);
        total  = exp_bits.size() * symlen;
        s      = 0;
        cyc    = 0;
        obs_bits.delete();
        @(negedge clk);
        i_m_dec  = m;
        i_trext  = tx;
        i_data   = d;
        i_len    = len;
        i_start  = 1'b1;
        i_en2blf = 1'b0;
        while (s < total) begin
            @(negedge clk);
            i_start = 1'b0;
            i_m_dec = 2'($urandom);
            i_trext = 1'($urandom);
            i_data  = 16'($urandom);
            i_len   = 5'($urandom);
            check("enable", o_enable_mod, 1);
            check("data", o_data_ocu, exp_bits[s / symlen]);
            check("violate", o_violate_mod, exp_vio[s / symlen]);
            check("busy", o_busy, 1);
            check("done_early", o_done, 0);
            if (s == clear_at) begin
                i_clear_cu = 1'b1;
                i_start    = 1'b1;
                i_en2blf   = 1'b1;
                @(negedge clk);
                i_clear_cu = 1'b0;
                i_start    = 1'b0;
                i_en2blf   = 1'b0;
                check("clr_enable", o_enable_mod, 0);
                check("clr_data", o_data_ocu, 0);
                check("clr_violate", o_violate_mod, 0);
                check("clr_busy", o_busy, 0);
                for (int k = 0; k < 3; k++) begin
                    check("clr_no_done", o_done, 0);
                    check("clr_idle", o_busy, 0);
                    @(negedge clk);
                end
                return;
            end
            strobe   = ((cyc % gap) == 0);
            i_en2blf = strobe;
            if (strobe && (s == spur)) i_start = 1'b1;
            if (strobe && (s % symlen == 0)) obs_bits.push_back(o_data_ocu);
            if (strobe) s++;
            cyc++;
        end
        @(negedge clk);
        i_en2blf = 1'b0;
        i_start  = 1'b0;
        check("end_enable", o_enable_mod, 0);
        check("end_data", o_data_ocu, 0);
        check("end_violate", o_violate_mod, 0);
        check("end_busy", o_busy, 1);
        check("end_done_early", o_done, 0);
        @(negedge clk);
        check("done_pulse", o_done, 1);
        check("done_idle", o_busy, 0);
        check("done_enable", o_enable_mod, 0);
        @(negedge clk);
        check("done_width", o_done, 0);
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [1:0]  rm;
        bit          rtx;
        logic [15:0] rd;
        logic [4:0]  rl;
        logic [15:0] res;

        vecs[0] = '{m: 2'd0, tx: 1'b0, d: 16'h000B, len: 5'd4, gap: 1, nsym: 11,
                    pat: 64'b10100110111, vio_sym: 4, spur: -1};
        vecs[1] = '{m: 2'd1, tx: 1'b0, d: 16'hFFFF, len: 5'd0, gap: 1, nsym: 11,
                    pat: 64'b00000101111, vio_sym: -1, spur: -1};
        vecs[2] = '{m: 2'd3, tx: 1'b1, d: 16'hFFFE, len: 5'd1, gap: 1, nsym: 24,
                    pat: 64'h00005D, vio_sym: -1, spur: -1};
        vecs[3] = '{m: 2'd0, tx: 1'b0, d: 16'h000B, len: 5'd4, gap: 3, nsym: 11,
                    pat: 64'b10100110111, vio_sym: 4, spur: 7};
        vecs[4] = '{m: 2'd0, tx: 1'b1, d: 16'hA5C3, len: 5'd31, gap: 1, nsym: 35,
                    pat: 64'({12'h000, 6'b101001, 16'hA5C3, 1'b1}), vio_sym: 16, spur: 20};
        vecs[5] = '{m: 2'd2, tx: 1'b0, d: 16'hFFF6, len: 5'd3, gap: 2, nsym: 14,
                    pat: 64'({4'h0, 6'b010111, 3'b110, 1'b1}), vio_sym: -1, spur: -1};

        rst        = 1'b1;
        i_m_dec    = 2'b00;
        i_trext    = 1'b0;
        i_en2blf   = 1'b0;
        i_start    = 1'b0;
        i_data     = 16'h0;
        i_len      = 5'd0;
        i_clear_cu = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", o_data_ocu, 0);
        check("rst_enable", o_enable_mod, 0);
        check("rst_violate", o_violate_mod, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", o_busy, 0);

        for (int i = 0; i < 6; i++) begin
            fill_table(vecs[i]);
            run_frame(vecs[i].m, vecs[i].tx, vecs[i].d, vecs[i].len, vecs[i].gap, -1, vecs[i].spur);
        end

        // Abort in the payload, with a same-cycle start that must lose to the clear.
        build_model(2'd0, 1'b0, 16'h00A5, 5'd8);
        run_frame(2'd0, 1'b0, 16'h00A5, 5'd8, 1, 14, -1);
        build_model(2'd2, 1'b1, 16'h5A5A, 5'd16);
        run_frame(2'd2, 1'b1, 16'h5A5A, 5'd16, 1, -1, -1);

        // Asynchronous reset mid-frame, away from any clock edge.
        @(negedge clk);
        i_m_dec = 2'd0; i_trext = 1'b1; i_data = 16'hFFFF; i_len = 5'd16; i_start = 1'b1;
        @(negedge clk);
        i_start  = 1'b0;
        i_en2blf = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_enable", o_enable_mod, 0);
        check("arst_data", o_data_ocu, 0);
        check("arst_busy", o_busy, 0);
        check("arst_violate", o_violate_mod, 0);
        check("arst_done", o_done, 0);
        @(negedge clk);
        rst      = 1'b0;
        i_en2blf = 1'b0;
        @(negedge clk);
        check("arst_idle", o_busy, 0);
        fill_table(vecs[0]);
        run_frame(vecs[0].m, vecs[0].tx, vecs[0].d, vecs[0].len, 1, -1, -1);

        for (int k = 0; k < 10; k++) begin
            rm  = 2'($urandom_range(0, 3));
            rtx = 1'($urandom);
            rd  = 16'($urandom);
            rl  = 5'($urandom_range(0, 20));
            build_model(rm, rtx, rd, rl);
            run_frame(rm, rtx, rd, rl, $urandom_range(1, 3), -1, $urandom_range(0, 40));
        end

`ifdef TX_FRAME_SER_CRC16_EN
        build_model(2'd0, 1'b0, 16'h1234, 5'd16);
        run_frame(2'd0, 1'b0, 16'h1234, 5'd16, 1, -1, -1);
        check("crc_obs_len", obs_bits.size(), 39);
        res = 16'hFFFF;
        for (int i = 6; i < 38 && i < obs_bits.size(); i++) res = crc_step(res, obs_bits[i]);
        check("crc_residue", res, 16'h1D0F);
`else
        res = 16'h0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
